ce_ls_arb: RTL and testbench
============================

CE_LS_ARB -- requirements
Module: ce_ls_arb

Interface
REQ-001 SHALL have parameter wData, default 35, meaning width of the real and imaginary sample buses.
REQ-002 SHALL have parameter wCnt, default 12, meaning width of the fftpts and beat-counter fields.
REQ-003 SHALL have one clock and synchronous active-high reset: clk input 1, the single rising-edge clock; rst_sync input 1, the synchronous active-high reset.
REQ-004 SHALL have, for each requester k in {0,1}, the following ports: sk_valid in 1; sk_ready out 1; sk_sop in 1; sk_eop in 1; sk_real in wData; sk_imag in wData; sk_fftpts in wCnt (frame length).
REQ-005 SHALL have the output ports m_valid out 1; m_ready in 1; m_sop out 1; m_eop out 1; m_real out wData; m_imag out wData; m_fftpts out wCnt; m_chan out 1 (owner index).
REQ-006 SHALL have the status ports len_err out 1 (one-cycle pulse) and orphan_cnt out 8 (saturating count).

Function
REQ-007 SHALL share one downstream LS scaler between two sample streams at frame granularity, so that a frame from sop to end is never interleaved.
REQ-008 SHALL implement the FSM states IDLE, GRANT, BUSY and FLUSH, stored in a registered state.
REQ-009 In IDLE, SHALL treat requester k as a candidate when sk_valid=1 and sk_sop=1.
REQ-010 When two candidates are present, SHALL pick the requester not in last_owner; a single candidate wins outright; the selected candidate enters GRANT and is latched as owner.
REQ-011 In GRANT, SHALL latch fftpts from the owner (a value of 0 means 4096), clear the beat counter, and enter BUSY on the next cycle, with no beat accepted in GRANT.
REQ-012 In BUSY, SHALL drive sk_ready = (k==owner) and (!m_valid or m_ready), and SHALL hold non-owner ready at 0.
REQ-013 SHALL register the output stage with latency 1: an accepted owner beat appears on m_* the next cycle, m_valid is held until m_ready, and throughput is 1 beat per clock.
REQ-014 SHALL pass m_sop only on the first beat of the frame; an owner sop mid-frame SHALL be forwarded with m_sop=0 and SHALL pulse len_err.
REQ-015 SHALL increment the beat counter on each accepted beat, and the frame end SHALL be the accepted beat with eop=1 or with counter+1 == latched fftpts, whichever comes first.
REQ-016 If eop arrives with counter+1 != fftpts, SHALL pass the beat with m_eop=1, pulse len_err, and end the frame.
REQ-017 If the count is reached without eop, SHALL force m_eop=1, pulse len_err, and enter FLUSH.
REQ-018 In FLUSH, SHALL drive owner ready=1 and discard owner beats up to and including the eop beat, then enter IDLE.
REQ-019 On a normal frame end, SHALL enter IDLE the cycle after the final beat is accepted and set last_owner=owner.
REQ-020 In IDLE, SHALL drive sk_ready=1 for valid beats without sop, discard those beats, and increment orphan_cnt, saturating at 255.
REQ-021 SHALL drive m_fftpts from the latched value and m_chan from the owner for the whole frame.
REQ-022 SHALL pass the data path unaltered (no scaling) with widths wData in and wData out.

Reset
REQ-023 SHALL hold the reset values while rst_sync=1 at a clk edge: state=IDLE, last_owner=1 (so requester 0 wins the first tie), all m_* outputs=0, sk_ready=0, len_err=0, orphan_cnt=0, beat counter=0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame without emitting m_eop, and the first post-reset frame SHALL start fresh.

Structure
REQ-025 SHALL place the FSM state encoding, the 4096 default and the orphan saturation limit in the shared ce package.
REQ-026 SHALL use one sub-module, ce_ls_outreg, which is the ready/valid output register, instantiated once.

Verification
REQ-027 Bench SHALL check: s0 sends a frame with fftpts=8 and 8 beats with eop on beat 8 -> m_chan=0, 8 beats out, m_sop on beat 1, m_eop on beat 8, len_err=0.
REQ-028 Bench SHALL check: s0 and s1 both present sop in the same cycle right after reset -> s0 served first; after its eop, s1 granted next; then s0 again on the next tie.
REQ-029 Bench SHALL check: fftpts=4 with eop on beat 2 -> 2 beats out, m_eop on beat 2, one len_err pulse, state IDLE.
REQ-030 Bench SHALL check: fftpts=4 with no eop until beat 6 -> 4 beats out with forced m_eop, len_err pulse, beats 5-6 discarded, and no output from them.
REQ-031 Bench SHALL check: m_ready toggled at 50% during a 16-beat frame -> no beat lost or duplicated and the data order is preserved.
REQ-032 Bench SHALL check: 3 valid beats without sop in IDLE, then rst_sync pulsed mid-frame -> orphan_cnt=3 before reset, all outputs 0 after reset, and the next frame correct.

Source files
------------

// File: rtl/ce_ls_arb_pkg.sv
// Shared definitions for the CE LS-scaler arbiter: FSM encoding, frame-length default
// and orphan counter limit.
package ce_ls_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // An fftpts field of zero stands for a full 4096-point frame.
  localparam int FFTPTS_DEFAULT = 4096;
  localparam int ORPHAN_MAX     = 255;

  function automatic logic [7:0] orphan_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'b0, inc};
    return (sum > 9'(ORPHAN_MAX)) ? 8'(ORPHAN_MAX) : sum[7:0];
  endfunction

endpackage

// File: rtl/ce_ls_outreg.sv
// Single-stage ready/valid output register: one beat of latency, full throughput,
// payload held stable while the downstream stalls.
module ce_ls_outreg #(
  parameter int wData = 35,
  parameter int wCnt  = 12
) (
  input  logic             clk,
  input  logic             rst_sync,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_sop_i,
  input  logic             in_eop_i,
  input  logic             in_chan_i,
  input  logic [wCnt-1:0]  in_fftpts_i,
  input  logic [wData-1:0] in_real_i,
  input  logic [wData-1:0] in_imag_i,
  input  logic             m_ready_i,
  output logic             m_valid_o,
  output logic             m_sop_o,
  output logic             m_eop_o,
  output logic             m_chan_o,
  output logic [wCnt-1:0]  m_fftpts_o,
  output logic [wData-1:0] m_real_o,
  output logic [wData-1:0] m_imag_o
);

  logic             valid_q, sop_q, eop_q, chan_q;
  logic [wCnt-1:0]  fftpts_q;
  logic [wData-1:0] real_q, imag_q;

  assign in_ready_o = ~valid_q | m_ready_i;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      chan_q   <= 1'b0;
      fftpts_q <= '0;
      real_q   <= '0;
      imag_q   <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q  <= 1'b1;
      sop_q    <= in_sop_i;
      eop_q    <= in_eop_i;
      chan_q   <= in_chan_i;
      fftpts_q <= in_fftpts_i;
      real_q   <= in_real_i;
      imag_q   <= in_imag_i;
    end else if (m_ready_i) begin
      valid_q  <= 1'b0;
    end
  end

  assign m_valid_o  = valid_q;
  assign m_sop_o    = sop_q;
  assign m_eop_o    = eop_q;
  assign m_chan_o   = chan_q;
  assign m_fftpts_o = fftpts_q;
  assign m_real_o   = real_q;
  assign m_imag_o   = imag_q;

endmodule

// File: rtl/ce_ls_arb.sv
// Frame-granular arbiter sharing one LS scaler between two sample streams; frames are
// never interleaved and malformed frames are truncated or flushed with a len_err pulse.
module ce_ls_arb
  import ce_ls_arb_pkg::*;
#(
  parameter int wData = 35,
  parameter int wCnt  = 12
) (
  input  logic             clk,
  input  logic             rst_sync,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic             s0_sop,
  input  logic             s0_eop,
  input  logic [wData-1:0] s0_real,
  input  logic [wData-1:0] s0_imag,
  input  logic [wCnt-1:0]  s0_fftpts,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic             s1_sop,
  input  logic             s1_eop,
  input  logic [wData-1:0] s1_real,
  input  logic [wData-1:0] s1_imag,
  input  logic [wCnt-1:0]  s1_fftpts,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sop,
  output logic             m_eop,
  output logic [wData-1:0] m_real,
  output logic [wData-1:0] m_imag,
  output logic [wCnt-1:0]  m_fftpts,
  output logic             m_chan,
  output logic             len_err,
  output logic [7:0]       orphan_cnt
);

  localparam int LenW = wCnt + 1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d, last_owner_q, last_owner_d;
  logic [LenW-1:0]   len_q, len_d, cnt_inc;
  logic [wCnt-1:0]   cnt_q, cnt_d;
  logic [7:0]        orphan_q, orphan_d;
  logic              len_err_q, len_err_d;
  logic              push, push_sop, push_eop, out_ready;
  logic              own_valid, own_sop, own_eop, cand0, cand1;
  logic [wCnt-1:0]   own_fft;
  logic [wData-1:0]  own_real, own_imag;

  assign own_valid = owner_q ? s1_valid  : s0_valid;
  assign own_sop   = owner_q ? s1_sop    : s0_sop;
  assign own_eop   = owner_q ? s1_eop    : s0_eop;
  assign own_fft   = owner_q ? s1_fftpts : s0_fftpts;
  assign own_real  = owner_q ? s1_real   : s0_real;
  assign own_imag  = owner_q ? s1_imag   : s0_imag;
  assign cand0     = s0_valid & s0_sop;
  assign cand1     = s1_valid & s1_sop;
  assign cnt_inc   = {1'b0, cnt_q} + LenW'(1);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    orphan_d     = orphan_q;
    len_err_d    = 1'b0;
    s0_ready     = 1'b0;
    s1_ready     = 1'b0;
    push         = 1'b0;
    push_sop     = 1'b0;
    push_eop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        s0_ready = s0_valid & ~s0_sop;
        s1_ready = s1_valid & ~s1_sop;
        orphan_d = orphan_add(orphan_q, {1'b0, s0_ready} + {1'b0, s1_ready});
        if (cand0 | cand1) begin
          owner_d = (cand0 & cand1) ? ~last_owner_q : cand1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        len_d   = (own_fft == '0) ? LenW'(FFTPTS_DEFAULT) : {1'b0, own_fft};
        cnt_d   = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        s0_ready = ~owner_q & out_ready;
        s1_ready = owner_q & out_ready;
        if (own_valid && out_ready) begin
          push     = 1'b1;
          push_sop = (cnt_q == '0);
          cnt_d    = cnt_inc[wCnt-1:0];
          if (own_sop && cnt_q != '0) len_err_d = 1'b1;
          // Frame ends on eop or on reaching the latched length, whichever is first.
          if (own_eop || cnt_inc == len_q) begin
            push_eop     = 1'b1;
            last_owner_d = owner_q;
            if (!(own_eop && cnt_inc == len_q)) len_err_d = 1'b1;
            state_d      = own_eop ? ST_IDLE : ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        s0_ready = ~owner_q;
        s1_ready = owner_q;
        if (own_valid && own_eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst_sync) begin
      s0_ready = 1'b0;
      s1_ready = 1'b0;
      push     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      len_q        <= '0;
      cnt_q        <= '0;
      orphan_q     <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      orphan_q     <= orphan_d;
      len_err_q    <= len_err_d;
    end
  end

  assign len_err    = len_err_q;
  assign orphan_cnt = orphan_q;

  ce_ls_outreg #(.wData(wData), .wCnt(wCnt)) u_outreg (
    .clk        (clk),
    .rst_sync   (rst_sync),
    .in_valid_i (push),
    .in_ready_o (out_ready),
    .in_sop_i   (push_sop),
    .in_eop_i   (push_eop),
    .in_chan_i  (owner_q),
    .in_fftpts_i(len_q[wCnt-1:0]),
    .in_real_i  (own_real),
    .in_imag_i  (own_imag),
    .m_ready_i  (m_ready),
    .m_valid_o  (m_valid),
    .m_sop_o    (m_sop),
    .m_eop_o    (m_eop),
    .m_chan_o   (m_chan),
    .m_fftpts_o (m_fftpts),
    .m_real_o   (m_real),
    .m_imag_o   (m_imag)
  );

endmodule

// File: tb/tb_ce_ls_arb.sv
// Self-checking bench for ce_ls_arb: random frame payloads scored against a
// frame-level reference model of the arbitration and framing rules.
module tb_ce_ls_arb;

  localparam int W = 35;
  localparam int C = 12;

  typedef struct packed {
    logic         sop;
    logic         eop;
    logic [C-1:0] fft;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } tx_t;

  typedef struct packed {
    logic         sop;
    logic         eop;
    logic         chan;
    logic [C-1:0] fft;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } out_t;

  logic clk, rst_sync;
  logic s0_valid, s0_ready, s0_sop, s0_eop;
  logic [W-1:0] s0_real, s0_imag;
  logic [C-1:0] s0_fftpts;
  logic s1_valid, s1_ready, s1_sop, s1_eop;
  logic [W-1:0] s1_real, s1_imag;
  logic [C-1:0] s1_fftpts;
  logic m_valid, m_ready, m_sop, m_eop, m_chan, len_err;
  logic [W-1:0] m_real, m_imag;
  logic [C-1:0] m_fftpts;
  logic [7:0] orphan_cnt;

  tx_t  txq0[$], txq1[$];
  out_t expq[$], got[$];
  int   total, bad, lenErrSeen, expErr, readyMode;
  logic lastOwnerModel;

  ce_ls_arb #(.wData(W), .wCnt(C)) dut (
    .clk(clk), .rst_sync(rst_sync),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_sop(s0_sop), .s0_eop(s0_eop),
    .s0_real(s0_real), .s0_imag(s0_imag), .s0_fftpts(s0_fftpts),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_sop(s1_sop), .s1_eop(s1_eop),
    .s1_real(s1_real), .s1_imag(s1_imag), .s1_fftpts(s1_fftpts),
    .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop),
    .m_real(m_real), .m_imag(m_imag), .m_fftpts(m_fftpts), .m_chan(m_chan),
    .len_err(len_err), .orphan_cnt(orphan_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream ready: always high, or a fair coin each cycle.
  initial begin
    forever begin
      @(negedge clk);
      m_ready = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Output monitor samples just before each rising edge.
  initial begin
    out_t o;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_sync && m_valid === 1'b1 && m_ready === 1'b1) begin
        o = {m_sop, m_eop, m_chan, m_fftpts, m_real, m_imag};
        got.push_back(o);
      end
      if (len_err === 1'b1) lenErrSeen++;
    end
  end

  task automatic set_inputs(input int k, input logic v, input tx_t b);
    if (k == 0) begin
      s0_valid = v; s0_sop = b.sop; s0_eop = b.eop;
      s0_real = b.re; s0_imag = b.im; s0_fftpts = b.fft;
    end else begin
      s1_valid = v; s1_sop = b.sop; s1_eop = b.eop;
      s1_real = b.re; s1_imag = b.im; s1_fftpts = b.fft;
    end
  endtask

  task automatic build_frame(input int k, input int fftRaw, input int n, input int eopAt,
                             input int sopMidAt, input bit withSop);
    tx_t b;
    tx_t q[$];
    logic [63:0] r;
    for (int i = 1; i <= n; i++) begin
      b.sop = (withSop && i == 1) || (i == sopMidAt);
      b.eop = (i == eopAt);
      b.fft = C'(fftRaw);
      r = {$urandom(), $urandom()};
      b.re = r[W-1:0];
      r = {$urandom(), $urandom()};
      b.im = r[W-1:0];
      q.push_back(b);
    end
    if (k == 0) txq0 = q; else txq1 = q;
  endtask

  // Reference: beats up to the first eop or the fftpts-th beat go out, sop only on the
  // first, eop on the last; len_err per emitted beat with a stray sop or a bad ending.
  task automatic model_frame(input int k);
    tx_t  q[$];
    out_t o;
    int   f;
    logic last, e;
    if (k == 0) q = txq0; else q = txq1;
    if (q.size() == 0) return;
    f = (q[0].fft == 0) ? 4096 : int'(q[0].fft);
    for (int j = 0; j < q.size(); j++) begin
      last = q[j].eop || (j + 1 == f);
      e = (j > 0 && q[j].sop) || (last && !(q[j].eop && j + 1 == f));
      if (e) expErr++;
      o.sop = (j == 0); o.eop = last; o.chan = k[0]; o.fft = q[0].fft;
      o.re = q[j].re; o.im = q[j].im;
      expq.push_back(o);
      if (last) begin
        lastOwnerModel = k[0];
        break;
      end
    end
  endtask

  task automatic drive(input int k);
    tx_t  q[$];
    int   budget;
    logic rdy;
    if (k == 0) q = txq0; else q = txq1;
    foreach (q[i]) begin
      set_inputs(k, 1'b1, q[i]);
      budget = 0;
      do begin
        #4;
        rdy = (k == 0) ? s0_ready : s1_ready;
        @(negedge clk);
        budget++;
      end while (rdy !== 1'b1 && budget < 1000);
      if (rdy !== 1'b1) begin
        total++; bad++;
        $display("[TB] FAIL handshake s%0d beat %0d: ready=%b after %0d cycles, want 1", k, i, rdy, budget);
        break;
      end
    end
    set_inputs(k, 1'b0, '0);
  endtask

  task automatic drain();
    int c = 0;
    while (got.size() < expq.size() && c < 500) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_sb();
    got.delete(); expq.delete(); lenErrSeen = 0; expErr = 0;
  endtask

  task automatic do_reset();
    rst_sync = 1'b1;
    repeat (2) @(negedge clk);
    rst_sync = 1'b0;
    lastOwnerModel = 1'b1;
  endtask

  task automatic test_reset();
    rst_sync = 1'b1;
    s0_valid = 1'b1; s0_sop = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({m_valid, m_sop, m_eop, m_chan, len_err} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset ctrl: got %b want 00000", {m_valid, m_sop, m_eop, m_chan, len_err});
    end
    total++;
    if ({m_real, m_imag, m_fftpts} !== '0) begin
      bad++; $display("[TB] FAIL reset data: got %h want 0", {m_real, m_imag, m_fftpts});
    end
    total++;
    if (orphan_cnt !== 8'd0) begin
      bad++; $display("[TB] FAIL reset orphan: got %0d want 0", orphan_cnt);
    end
    total++;
    if ({s0_ready, s1_ready} !== 2'b00) begin
      bad++; $display("[TB] FAIL reset ready: got %b want 00", {s0_ready, s1_ready});
    end
    s0_valid = 1'b0;
    @(negedge clk);
    rst_sync = 1'b0;
    lastOwnerModel = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    clear_sb();
    build_frame(0, 8, 8, 8, 0, 1);
    model_frame(0);
    drive(0);
    drain();
    total++;
    if (got.size() != expq.size()) begin
      bad++; $display("[TB] FAIL basic count: got %0d want %0d", got.size(), expq.size());
    end
    foreach (expq[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== expq[i]) begin bad++; $display("[TB] FAIL basic beat %0d: got %h want %h", i, got[i], expq[i]); end
    end
    total++;
    if (lenErrSeen != expErr) begin bad++; $display("[TB] FAIL basic len_err: got %0d want %0d", lenErrSeen, expErr); end
  endtask

  task automatic test_tie();
    logic first;
    do_reset();
    clear_sb();
    repeat (2) begin
      build_frame(0, 5, 5, 5, 0, 1);
      build_frame(1, 6, 6, 6, 0, 1);
      first = ~lastOwnerModel;
      model_frame(int'(first));
      model_frame(int'(~first));
      fork
        drive(0);
        drive(1);
      join
    end
    drain();
    total++;
    if (got.size() != expq.size()) begin
      bad++; $display("[TB] FAIL tie count: got %0d want %0d", got.size(), expq.size());
    end
    foreach (expq[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== expq[i]) begin bad++; $display("[TB] FAIL tie beat %0d: got %h want %h", i, got[i], expq[i]); end
    end
    total++;
    if (lenErrSeen != expErr) begin bad++; $display("[TB] FAIL tie len_err: got %0d want %0d", lenErrSeen, expErr); end
  endtask

  task automatic test_short_eop();
    logic rdy;
    clear_sb();
    build_frame(0, 4, 2, 2, 0, 1);
    model_frame(0);
    drive(0);
    drain();
    total++;
    if (got.size() != expq.size()) begin
      bad++; $display("[TB] FAIL short count: got %0d want %0d", got.size(), expq.size());
    end
    foreach (expq[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== expq[i]) begin bad++; $display("[TB] FAIL short beat %0d: got %h want %h", i, got[i], expq[i]); end
    end
    total++;
    if (lenErrSeen != expErr) begin bad++; $display("[TB] FAIL short len_err: got %0d want %0d", lenErrSeen, expErr); end
    // Back in IDLE a sop-less beat is taken as an orphan.
    s1_valid = 1'b1; s1_sop = 1'b0;
    #4;
    rdy = s1_ready;
    @(negedge clk);
    s1_valid = 1'b0;
    total++;
    if (rdy !== 1'b1) begin bad++; $display("[TB] FAIL short idle: ready=%b want 1", rdy); end
  endtask

  task automatic test_overrun();
    clear_sb();
    build_frame(1, 4, 6, 6, 0, 1);
    model_frame(1);
    drive(1);
    build_frame(0, 0, 5, 5, 0, 1);
    model_frame(0);
    drive(0);
    drain();
    total++;
    if (got.size() != expq.size()) begin
      bad++; $display("[TB] FAIL overrun count: got %0d want %0d", got.size(), expq.size());
    end
    foreach (expq[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== expq[i]) begin bad++; $display("[TB] FAIL overrun beat %0d: got %h want %h", i, got[i], expq[i]); end
    end
    total++;
    if (lenErrSeen != expErr) begin bad++; $display("[TB] FAIL overrun len_err: got %0d want %0d", lenErrSeen, expErr); end
  endtask

  task automatic test_backpressure();
    clear_sb();
    readyMode = 1;
    build_frame(1, 16, 16, 16, 0, 1);
    model_frame(1);
    drive(1);
    drain();
    readyMode = 0;
    total++;
    if (got.size() != expq.size()) begin
      bad++; $display("[TB] FAIL bp count: got %0d want %0d", got.size(), expq.size());
    end
    foreach (expq[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== expq[i]) begin bad++; $display("[TB] FAIL bp beat %0d: got %h want %h", i, got[i], expq[i]); end
    end
    total++;
    if (lenErrSeen != expErr) begin bad++; $display("[TB] FAIL bp len_err: got %0d want %0d", lenErrSeen, expErr); end
  endtask

  task automatic test_random_frames();
    int k, f, n, sm;
    clear_sb();
    readyMode = 1;
    repeat (10) begin
      k  = $urandom_range(0, 1);
      f  = $urandom_range(1, 8);
      n  = $urandom_range(1, 10);
      sm = (n > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(2, n) : 0;
      build_frame(k, f, n, n, sm, 1);
      model_frame(k);
      drive(k);
    end
    drain();
    readyMode = 0;
    total++;
    if (got.size() != expq.size()) begin
      bad++; $display("[TB] FAIL random count: got %0d want %0d", got.size(), expq.size());
    end
    foreach (expq[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== expq[i]) begin bad++; $display("[TB] FAIL random beat %0d: got %h want %h", i, got[i], expq[i]); end
    end
    total++;
    if (lenErrSeen != expErr) begin bad++; $display("[TB] FAIL random len_err: got %0d want %0d", lenErrSeen, expErr); end
  endtask

  task automatic test_orphan_reset();
    do_reset();
    clear_sb();
    build_frame(0, 8, 3, 0, 0, 0);
    drive(0);
    @(negedge clk);
    total++;
    if (orphan_cnt !== 8'd3) begin bad++; $display("[TB] FAIL orphan count: got %0d want 3", orphan_cnt); end
    total++;
    if (got.size() != 0) begin bad++; $display("[TB] FAIL orphan output: got %0d beats want 0", got.size()); end
    // Partial frame, then reset while it is still open.
    build_frame(0, 8, 3, 0, 0, 1);
    model_frame(0);
    drive(0);
    drain();
    total++;
    if (got.size() != expq.size()) begin
      bad++; $display("[TB] FAIL partial count: got %0d want %0d", got.size(), expq.size());
    end
    foreach (expq[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== expq[i]) begin bad++; $display("[TB] FAIL partial beat %0d: got %h want %h", i, got[i], expq[i]); end
    end
    rst_sync = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({m_valid, m_sop, m_eop, m_chan, len_err, m_real, m_imag, m_fftpts, orphan_cnt} !== '0) begin
      bad++; $display("[TB] FAIL midreset outputs: got %h want 0",
                      {m_valid, m_sop, m_eop, m_chan, len_err, m_real, m_imag, m_fftpts, orphan_cnt});
    end
    rst_sync = 1'b0;
    lastOwnerModel = 1'b1;
    clear_sb();
    build_frame(0, 8, 8, 8, 0, 1);
    model_frame(0);
    drive(0);
    drain();
    total++;
    if (got.size() != expq.size()) begin
      bad++; $display("[TB] FAIL postreset count: got %0d want %0d", got.size(), expq.size());
    end
    foreach (expq[i]) if (i < got.size()) begin
      total++;
      if (got[i] !== expq[i]) begin bad++; $display("[TB] FAIL postreset beat %0d: got %h want %h", i, got[i], expq[i]); end
    end
    total++;
    if (lenErrSeen != expErr) begin bad++; $display("[TB] FAIL postreset len_err: got %0d want %0d", lenErrSeen, expErr); end
  endtask

  initial begin
    total = 0; bad = 0; readyMode = 0; lenErrSeen = 0; expErr = 0;
    lastOwnerModel = 1'b1;
    rst_sync = 1'b1; m_ready = 1'b1;
    set_inputs(0, 1'b0, '0);
    set_inputs(1, 1'b0, '0);
    test_reset();
    test_basic_frame();
    test_tie();
    test_short_eop();
    test_overrun();
    test_backpressure();
    test_random_frames();
    test_orphan_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
